wb_ctrl: RTL and testbench
==========================

Name: wb_ctrl

Overview:
- Writeback controller for the register-file write port.
- Accepts one retiring instruction at a time from the execute stage.
- Drives the writeback mux select (rd_data_sel_t) plus rf write enable and address.
- Holds the write port across variable-latency loads until the LSU returns data; supports pipeline flush and load timeout.
- Publishes the pending destination register so hazard logic can stall dependents.

Parameters:
- TIMEOUT, 256, max cycles spent waiting for lsu_rvalid before abandoning a load (>=2).
- CNT_W, $clog2(TIMEOUT+1), load wait counter width (derived, not overridden).

Ports:
- clk  input  1  system clock; everything on rising edge
- rstn  input  1  synchronous, active-low reset
- wb_valid  input  1  retiring instruction presented
- wb_ready  output  1  controller can accept instruction this cycle
- wb_rd  input  5  destination register index
- wb_sel  input  rd_data_sel_t(3)  writeback source for this instruction
- flush  input  1  cancel current/pending writeback
- lsu_rvalid  input  1  load data valid on data-memory read bus this cycle
- rd_data_sel  output  rd_data_sel_t(3)  select to writeback mux
- rf_we  output  1  register-file write enable
- rf_waddr  output  5  register-file write address
- busy  output  1  load outstanding (WAIT_LOAD)
- busy_rd  output  5  destination of outstanding load (0 when not busy)
- retire  output  1  instruction completed writeback this cycle
- load_fault  output  1  one-cycle pulse: load timed out

Behaviour:
- One clock; reset is synchronous and active-low (clk, rstn).
- rstn=0 at a clock edge: state<=IDLE, counter<=0, pending_rd<=0, load_fault<=0. While rstn=0, combinational outputs are forced: wb_ready=0, rf_we=0, retire=0.
- Output timing:
  - rd_data_sel, rf_we, rf_waddr, wb_ready and retire are combinational from state and inputs, so the mux output and rf_we align in the same cycle.
  - busy, busy_rd and load_fault are registered.
- Idle output defaults: rd_data_sel=MAIN_ALU_RESULT, rf_we=0, rf_waddr=0, busy=0, busy_rd=0.
- x0 rule: rf_we is never asserted when the address is 0. retire is still asserted.
- IDLE (wb_ready=1):
  - wb_valid & !flush & wb_sel!=DATA_MEM_RDATA: rd_data_sel=wb_sel, rf_waddr=wb_rd, rf_we=(wb_rd!=0), retire=1. Stay IDLE. Zero-latency writeback.
  - wb_valid & !flush & wb_sel==DATA_MEM_RDATA: no write. pending_rd<=wb_rd, counter<=0, go to WAIT_LOAD.
  - wb_valid & flush: instruction dropped; no write, no retire.
  - lsu_rvalid in IDLE: ignored.
  - Undefined wb_sel encodings: treated as non-load and passed through to the mux.
- WAIT_LOAD (wb_ready=0, busy=1, busy_rd=pending_rd):
  - Drives rd_data_sel=DATA_MEM_RDATA and rf_waddr=pending_rd.
  - flush: go to DRAIN (or IDLE if lsu_rvalid is also high this cycle; the response is discarded). Flush takes priority over rvalid; no write.
  - lsu_rvalid & !flush: rf_we=(pending_rd!=0), retire=1, go to IDLE.
  - Otherwise counter++. When counter==TIMEOUT-1 with no rvalid: go to IDLE, load_fault<=1 for the next cycle only. No write, no retire.
- DRAIN (wb_ready=0, busy=0, rf_we=0):
  - Consumes one late lsu_rvalid, then goes to IDLE.
  - Counter continues; on TIMEOUT expiry goes to IDLE silently (no load_fault).
- Responses after a timeout are not tracked; the LSU guarantees at most one outstanding load.
- Counter saturation: the counter never wraps; it is cleared on every entry to WAIT_LOAD and DRAIN.
- Reset mid-load: pending state is lost; no write is issued.

Test Plan:
- ALU write: reset, then wb_valid=1, wb_rd=5, wb_sel=MAIN_ALU_RESULT -> same cycle rf_we=1, rf_waddr=5, rd_data_sel=MAIN_ALU_RESULT, retire=1; wb_ready stays 1.
- Load, 3-cycle latency: wb_sel=DATA_MEM_RDATA, wb_rd=12; lsu_rvalid 3 cycles later -> wb_ready=0 and busy=1, busy_rd=12 for 3 cycles; rf_we=1, rf_waddr=12 in the rvalid cycle; next cycle IDLE, busy=0.
- x0 suppression: LUI_IMM to rd=0, and a load to rd=0 -> retire=1, rf_we=0 in both cases.
- Flush during load: load to rd=7, flush 1 cycle later, lsu_rvalid 2 cycles after that -> no rf_we; state DRAIN until the rvalid, then IDLE. Next ALU op writes normally.
- Simultaneous flush+rvalid: in WAIT_LOAD -> no write, next state IDLE (not DRAIN).
- Timeout: TIMEOUT=4, load with no rvalid -> load_fault pulses exactly 1 cycle, 5 cycles after acceptance; wb_ready=1 afterwards; no retire.

Source files
------------

// File: rtl/wb_ctrl.sv
// Writeback controller: picks the rf write source and holds the write port until a load's data returns.
// Latency: 0 cycles for non-load writebacks; loads retire in the lsu_rvalid cycle. wb_ready is low while a load is outstanding.
package wb_ctrl_pkg;
    typedef enum logic [2:0] {
        MAIN_ALU_RESULT = 3'd0,
        DATA_MEM_RDATA  = 3'd1,
        LUI_IMM         = 3'd2,
        PC_PLUS4        = 3'd3,
        CSR_RDATA       = 3'd4
    } rd_data_sel_t;
endpackage

module wb_ctrl
    import wb_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         wb_valid,
    output logic         wb_ready,
    input  logic [4:0]   wb_rd,
    input  rd_data_sel_t wb_sel,
    input  logic         flush,
    input  logic         lsu_rvalid,
    output rd_data_sel_t rd_data_sel,
    output logic         rf_we,
    output logic [4:0]   rf_waddr,
    output logic         busy,
    output logic [4:0]   busy_rd,
    output logic         retire,
    output logic         load_fault
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_LOAD, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       pend_q, pend_d;
    logic             fault_d;
    logic             ready_raw, we_raw, retire_raw;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pend_q     <= '0;
            busy       <= 1'b0;
            busy_rd    <= '0;
            load_fault <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            busy       <= (state_d == WAIT_LOAD);
            busy_rd    <= (state_d == WAIT_LOAD) ? pend_d : 5'd0;
            load_fault <= fault_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        fault_d     = 1'b0;
        rd_data_sel = MAIN_ALU_RESULT;
        rf_waddr    = 5'd0;
        ready_raw   = 1'b0;
        we_raw      = 1'b0;
        retire_raw  = 1'b0;
        case (state_q)
            IDLE: begin
                ready_raw = 1'b1;
                if (wb_valid && !flush) begin
                    if (wb_sel == DATA_MEM_RDATA) begin
                        pend_d  = wb_rd;
                        cnt_d   = '0;
                        state_d = WAIT_LOAD;
                    end else begin
                        // Any other encoding, defined or not, goes straight to the mux.
                        rd_data_sel = wb_sel;
                        rf_waddr    = wb_rd;
                        we_raw      = 1'b1;
                        retire_raw  = 1'b1;
                    end
                end
            end
            WAIT_LOAD: begin
                rd_data_sel = DATA_MEM_RDATA;
                rf_waddr    = pend_q;
                if (flush) begin
                    // A response arriving with the flush is the one being cancelled.
                    cnt_d   = '0;
                    state_d = lsu_rvalid ? IDLE : DRAIN;
                end else if (lsu_rvalid) begin
                    we_raw     = 1'b1;
                    retire_raw = 1'b1;
                    state_d    = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    fault_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (lsu_rvalid || cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wb_ready = rstn & ready_raw;
    assign rf_we    = rstn & we_raw & (rf_waddr != 5'd0);
    assign retire   = rstn & retire_raw;
endmodule

// File: tb/tb_wb_ctrl.sv
// Bench for wb_ctrl with TIMEOUT=4: directed vectors, literal spot checks and a per-cycle reference model.
module tb_wb_ctrl;
    import wb_ctrl_pkg::*;

    localparam int TO = 4;
    localparam int M_IDLE = 0, M_LOAD = 1, M_DRAIN = 2;

    logic         clk = 1'b0;
    logic         rstn, wb_valid, flush, lsu_rvalid;
    logic [4:0]   wb_rd;
    rd_data_sel_t wb_sel;
    logic         wb_ready, rf_we, busy, retire, load_fault;
    logic [4:0]   rf_waddr, busy_rd;
    rd_data_sel_t rd_data_sel;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: what kind of wait is open, for which rd, and how long it has lasted.
    int         m_mode  = M_IDLE;
    logic [4:0] m_rd    = 5'd0;
    int         m_age   = 0;
    logic       m_fault = 1'b0;

    wb_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rd(wb_rd), .wb_sel(wb_sel), .flush(flush), .lsu_rvalid(lsu_rvalid),
        .rd_data_sel(rd_data_sel), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .busy(busy), .busy_rd(busy_rd), .retire(retire), .load_fault(load_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [4:0] rd,
                         input rd_data_sel_t sel, input logic fl, input logic rv);
        @(posedge clk);
        #1;
        rstn = r; wb_valid = v; wb_rd = rd; wb_sel = sel; flush = fl; lsu_rvalid = rv;
        #1;
    endtask

    task automatic idle_cyc(input logic rv);
        drive(1'b1, 1'b0, 5'd0, MAIN_ALU_RESULT, 1'b0, rv);
    endtask

    // Compare every cycle at the falling edge, then advance the model across the next rising edge.
    always @(negedge clk) begin
        logic       e_rdy, e_we, e_ret;
        logic [4:0] e_addr;
        logic [2:0] e_sel;
        logic       accept;
        accept = wb_valid && !flush;
        e_rdy = 1'b0; e_we = 1'b0; e_ret = 1'b0; e_addr = 5'd0; e_sel = 3'(MAIN_ALU_RESULT);
        if (m_mode == M_IDLE) begin
            e_rdy = 1'b1;
            if (accept && wb_sel != DATA_MEM_RDATA) begin
                e_sel = 3'(wb_sel); e_addr = wb_rd; e_ret = 1'b1; e_we = (wb_rd != 5'd0);
            end
        end else if (m_mode == M_LOAD) begin
            e_sel = 3'(DATA_MEM_RDATA); e_addr = m_rd;
            e_ret = lsu_rvalid && !flush;
            e_we  = e_ret && (m_rd != 5'd0);
        end
        if (!rstn) begin
            e_rdy = 1'b0; e_we = 1'b0; e_ret = 1'b0;
        end
        chk("m_wb_ready", 8'(wb_ready), 8'(e_rdy));
        chk("m_rf_we", 8'(rf_we), 8'(e_we));
        chk("m_retire", 8'(retire), 8'(e_ret));
        if (rstn && m_mode != M_DRAIN) begin
            chk("m_rd_data_sel", 8'(rd_data_sel), 8'(e_sel));
            chk("m_rf_waddr", 8'(rf_waddr), 8'(e_addr));
        end
        chk("m_busy", 8'(busy), 8'(m_mode == M_LOAD));
        chk("m_busy_rd", 8'(busy_rd), (m_mode == M_LOAD) ? 8'(m_rd) : 8'd0);
        chk("m_load_fault", 8'(load_fault), 8'(m_fault));

        m_fault = 1'b0;
        if (!rstn) begin
            m_mode = M_IDLE; m_age = 0;
        end else if (m_mode == M_IDLE) begin
            if (accept && wb_sel == DATA_MEM_RDATA) begin
                m_mode = M_LOAD; m_rd = wb_rd; m_age = 0;
            end
        end else if (m_mode == M_LOAD) begin
            if (flush) begin
                m_mode = lsu_rvalid ? M_IDLE : M_DRAIN; m_age = 0;
            end else if (lsu_rvalid) begin
                m_mode = M_IDLE;
            end else if (m_age + 1 == TO) begin
                m_mode = M_IDLE; m_fault = 1'b1;
            end else begin
                m_age++;
            end
        end else begin
            if (lsu_rvalid || m_age + 1 == TO) m_mode = M_IDLE;
            else m_age++;
        end
    end

    initial begin
        rstn = 1'b0; wb_valid = 1'b0; wb_rd = 5'd0; wb_sel = MAIN_ALU_RESULT;
        flush = 1'b0; lsu_rvalid = 1'b0;

        drive(1'b0, 1'b1, 5'd5, MAIN_ALU_RESULT, 1'b0, 1'b0);
        chk("rst_wb_ready", 8'(wb_ready), 8'd0);
        chk("rst_rf_we", 8'(rf_we), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_load_fault", 8'(load_fault), 8'd0);

        // ALU writeback, same cycle
        drive(1'b1, 1'b1, 5'd5, MAIN_ALU_RESULT, 1'b0, 1'b0);
        chk("alu_we", 8'(rf_we), 8'd1);
        chk("alu_waddr", 8'(rf_waddr), 8'd5);
        chk("alu_sel", 8'(rd_data_sel), 8'd0);
        chk("alu_retire", 8'(retire), 8'd1);
        chk("alu_ready", 8'(wb_ready), 8'd1);

        // Load with 3-cycle latency
        drive(1'b1, 1'b1, 5'd12, DATA_MEM_RDATA, 1'b0, 1'b0);
        chk("ld_accept_we", 8'(rf_we), 8'd0);
        idle_cyc(1'b0);
        chk("ld_ready_lo", 8'(wb_ready), 8'd0);
        chk("ld_busy", 8'(busy), 8'd1);
        chk("ld_busy_rd", 8'(busy_rd), 8'd12);
        idle_cyc(1'b0);
        idle_cyc(1'b1);
        chk("ld_we", 8'(rf_we), 8'd1);
        chk("ld_waddr", 8'(rf_waddr), 8'd12);
        chk("ld_sel", 8'(rd_data_sel), 8'd1);
        idle_cyc(1'b0);
        chk("ld_done_busy", 8'(busy), 8'd0);
        chk("ld_done_ready", 8'(wb_ready), 8'd1);

        // x0 suppression, immediate and load
        drive(1'b1, 1'b1, 5'd0, LUI_IMM, 1'b0, 1'b0);
        chk("x0_lui_retire", 8'(retire), 8'd1);
        chk("x0_lui_we", 8'(rf_we), 8'd0);
        drive(1'b1, 1'b1, 5'd0, DATA_MEM_RDATA, 1'b0, 1'b0);
        idle_cyc(1'b1);
        chk("x0_ld_retire", 8'(retire), 8'd1);
        chk("x0_ld_we", 8'(rf_we), 8'd0);

        // Undefined select passes through; flushed instruction is dropped
        drive(1'b1, 1'b1, 5'd9, rd_data_sel_t'(3'd6), 1'b0, 1'b0);
        chk("undef_sel", 8'(rd_data_sel), 8'd6);
        chk("undef_we", 8'(rf_we), 8'd1);
        drive(1'b1, 1'b1, 5'd4, MAIN_ALU_RESULT, 1'b1, 1'b0);
        chk("idle_flush_retire", 8'(retire), 8'd0);

        // Flush during load, late response drained
        drive(1'b1, 1'b1, 5'd7, DATA_MEM_RDATA, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 5'd0, MAIN_ALU_RESULT, 1'b1, 1'b0);
        chk("fl_we", 8'(rf_we), 8'd0);
        idle_cyc(1'b0);
        chk("drain_busy", 8'(busy), 8'd0);
        chk("drain_ready", 8'(wb_ready), 8'd0);
        idle_cyc(1'b1);
        chk("drain_rv_we", 8'(rf_we), 8'd0);
        drive(1'b1, 1'b1, 5'd9, MAIN_ALU_RESULT, 1'b0, 1'b0);
        chk("post_drain_we", 8'(rf_we), 8'd1);
        chk("post_drain_waddr", 8'(rf_waddr), 8'd9);

        // Flush together with rvalid returns straight to IDLE
        drive(1'b1, 1'b1, 5'd3, DATA_MEM_RDATA, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 5'd0, MAIN_ALU_RESULT, 1'b1, 1'b1);
        chk("flrv_we", 8'(rf_we), 8'd0);
        idle_cyc(1'b0);
        chk("flrv_ready", 8'(wb_ready), 8'd1);

        // Load timeout: fault pulse 5 cycles after acceptance
        drive(1'b1, 1'b1, 5'd10, DATA_MEM_RDATA, 1'b0, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            idle_cyc(1'b0);
            chk("to_fault", 8'(load_fault), (i == 5) ? 8'd1 : 8'd0);
            chk("to_retire", 8'(retire), 8'd0);
        end
        chk("to_ready", 8'(wb_ready), 8'd1);
        idle_cyc(1'b1);
        chk("stale_rv_we", 8'(rf_we), 8'd0);

        // Drain expiry is silent
        drive(1'b1, 1'b1, 5'd11, DATA_MEM_RDATA, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 5'd0, MAIN_ALU_RESULT, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            idle_cyc(1'b0);
            chk("drto_ready", 8'(wb_ready), (i >= 4) ? 8'd1 : 8'd0);
            chk("drto_fault", 8'(load_fault), 8'd0);
        end

        // Reset mid-load loses the pending write
        drive(1'b1, 1'b1, 5'd13, DATA_MEM_RDATA, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 5'd0, MAIN_ALU_RESULT, 1'b0, 1'b1);
        chk("rst_ld_we", 8'(rf_we), 8'd0);
        chk("rst_ld_ready", 8'(wb_ready), 8'd0);
        idle_cyc(1'b0);
        chk("rst_ld_busy", 8'(busy), 8'd0);
        chk("rst_ld_ready2", 8'(wb_ready), 8'd1);
        idle_cyc(1'b0);

        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
